icache_resp_unit: RTL and testbench
===================================

# icache_resp_unit

- Responder end of the CPU↔ICache fetch protocol.
- Consumes `req_cpu_icache_t` from the fetch-stage icache interface and returns `resp_icache_cpu_t`.
- Keeps a small direct-mapped store of 128-bit lines (`icache_line_t`) and refills misses from a valid/ready memory port.
- Used as the simulation/FPGA instruction cache behind fetch, and as the fetch-side endpoint in core-level benches.

## Interface
Parameters:
- `NUM_LINES`, 8: number of lines; power of two, ≥2. `IDX = log2(NUM_LINES)`.

Ports:
- `clk_i`  in  1  single clock
- `rstn_i`  in  1  reset, synchronous, active-low
- `req_cpu_icache_i`  in  `req_cpu_icache_t`  valid, 40-bit vaddr, invalidate_icache
- `ready_o`  out  1  request is accepted on any edge where `valid && ready_o`
- `resp_icache_cpu_o`  out  `resp_icache_cpu_t`  valid, 32-bit data, instr_access_fault, instr_page_fault
- `mem_req_valid_o`  out  1  refill request
- `mem_req_addr_o`  out  `addr_t`  line-aligned address, bits [3:0] = 0
- `mem_req_ready_i`  in  1  memory accepts the refill request
- `mem_resp_valid_i`  in  1  refill line returned (single beat)
- `mem_resp_data_i`  in  `icache_line_t`  refill line
- `mem_resp_error_i`  in  1  bus error on the refill

## Operation
- Address split:
  - word select = vaddr[3:2]; vaddr[1:0] is ignored.
  - index = vaddr[4+IDX-1:4].
  - tag = vaddr[39:4+IDX].
- States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESPOND.
- IDLE: `ready_o`=1.
  - Accepted request: latch vaddr, go to LOOKUP.
  - Invalidate with no valid request: clear all valid bits, stay in IDLE, no response.
- LOOKUP: compare the latched tag against the stored tag and valid bit at the latched index.
  - Hit: drive resp valid=1 with data = selected word of the stored line.
  - On hit, `ready_o`=1, so back-to-back hits run at one per cycle. A new request goes to LOOKUP; otherwise go to IDLE.
  - Miss: `ready_o`=0, resp valid=0, go to MISS_REQ.
- MISS_REQ: `mem_req_valid_o`=1 with `{vaddr[39:4],4'b0}`, held stable until `mem_req_ready_i`, then go to MISS_WAIT.
- MISS_WAIT: wait for `mem_resp_valid_i`.
  - No error: write line, tag and valid bit; capture the line.
  - Error: do not install the line; record the fault.
  - Either case: go to RESPOND.
- RESPOND: resp valid=1.
  - No error: data = captured word, fault bits 0.
  - Error: data=0, instr_access_fault=1.
  - `ready_o`=0; go to IDLE.
- `instr_page_fault` is always 0; this block does no translation.
- Invalidate together with valid in an accepted cycle: clear all valid bits first; the lookup in the next cycle therefore misses.
- Requests and invalidates are sampled only when `ready_o`=1. The requester holds them (Replay) otherwise.
- `mem_resp_valid_i` outside MISS_WAIT is ignored.

## Timing
- Reset: all outputs 0 (`ready_o`=0 while `rstn_i`=0), all valid bits cleared, state IDLE. `ready_o`=1 in the first cycle after release.
- Reset mid-miss aborts the miss. No response is produced and no line is installed.
- Hit latency: accepted at edge N, response valid during cycle N+1 (1 cycle).
- Miss latency: accepted at edge N.
  - `mem_req_valid_o` high from cycle N+1.
  - Response in the cycle after `mem_resp_valid_i` is sampled.
  - Minimum 4 cycles (N+1 LOOKUP, MISS_REQ, MISS_WAIT, RESPOND).
- resp valid is a single-cycle pulse per accepted fetch, and responses come back in request order.
- Invalidate completes in one edge. A fetch accepted on the next edge sees an empty store.

## Structure
- Add to `drac_pkg`:
  - `icache_resp_state_t` (5-state enum).
  - `mem_icache_req_t` {valid, addr_t addr}.
  - `mem_icache_resp_t` {valid, icache_line_t data, error}.
- The icache/fetch-side types already there are reused unchanged.
- Sub-module `icache_resp_array`: tag/valid/data storage.
  - Combinational read by index.
  - Synchronous write.
  - Single-cycle flash-clear of valid bits.
- The FSM, request latch and word mux stay in `icache_resp_unit`.

## Test plan
- Cold miss: fetch 0x00_0000_1004 → `mem_req_addr_o`=0x00_0000_1000. Return line 0x4444…_3333…_2222…_1111… → resp data=0x22222222, faults 0.
- Hit stream: fetches 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles after the fill → four consecutive resp valids (0x11111111, 0x22222222, 0x33333333, 0x44444444), `ready_o` never drops, no `mem_req_valid_o`.
- Conflict: NUM_LINES=8, fetch 0x1000 then 0x1080 (same index, different tag) → second fetch misses and refills. Re-fetching 0x1000 then misses again.
- Error: `mem_resp_error_i`=1 on refill of 0x2000 → resp valid with access_fault=1, data=0. A retry of 0x2000 issues a new memory request.
- Invalidate: after a fill of 0x1000, pulse invalidate with valid=0, then fetch 0x1000 → miss and new memory request.
- Backpressure/reset: hold `mem_req_ready_i`=0 for 5 cycles → `mem_req_valid_o` and the address are stable throughout. Assert `rstn_i`=0 in MISS_WAIT → no response, `ready_o`=1 after release, and a late `mem_resp_valid_i` is ignored.

Source files
------------

// File: rtl/drac_pkg.sv
// Shared fetch-side types for the CPU<->ICache protocol and the icache responder.
package drac_pkg;

  typedef logic [39:0]  addr_t;
  typedef logic [127:0] icache_line_t;

  localparam int unsigned ICACHE_WORD_W  = 32;
  localparam int unsigned ICACHE_OFFSET_W = 4;

  typedef struct packed {
    logic  valid;
    addr_t vaddr;
    logic  invalidate_icache;
  } req_cpu_icache_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        instr_access_fault;
    logic        instr_page_fault;
  } resp_icache_cpu_t;

  typedef enum logic [2:0] {
    ICR_IDLE      = 3'd0,
    ICR_LOOKUP    = 3'd1,
    ICR_MISS_REQ  = 3'd2,
    ICR_MISS_WAIT = 3'd3,
    ICR_RESPOND   = 3'd4
  } icache_resp_state_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } mem_icache_req_t;

  typedef struct packed {
    logic         valid;
    icache_line_t data;
    logic         error;
  } mem_icache_resp_t;

  // Word 0 sits in the least significant 32 bits of the line.
  function automatic logic [31:0] icache_word_sel(input icache_line_t line, input logic [1:0] sel);
    logic [31:0] word;
    case (sel)
      2'd0:    word = line[31:0];
      2'd1:    word = line[63:32];
      2'd2:    word = line[95:64];
      2'd3:    word = line[127:96];
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/icache_resp_array.sv
// Direct-mapped tag/valid/data store: combinational read, synchronous write,
// single-cycle flash-clear of all valid bits.
module icache_resp_array
  import drac_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned TAG_W     = 33
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               clear_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output icache_line_t       rd_line_o,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  icache_line_t       wr_line_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  icache_line_t         line_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = line_q[rd_idx_i];

  // Flash-clear takes priority over a fill in the same cycle.
  always_comb begin
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = '0;
    end else if (we_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      line_q[wr_idx_i] <= wr_line_i;
    end
  end

endmodule

// File: rtl/icache_resp_unit.sv
// Responder end of the CPU<->ICache fetch protocol: direct-mapped line store
// refilled over a valid/ready memory port, one response per accepted fetch.
module icache_resp_unit
  import drac_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  req_cpu_icache_t  req_cpu_icache_i,
  output logic             ready_o,
  output resp_icache_cpu_t resp_icache_cpu_o,
  output logic             mem_req_valid_o,
  output addr_t            mem_req_addr_o,
  input  logic             mem_req_ready_i,
  input  logic             mem_resp_valid_i,
  input  icache_line_t     mem_resp_data_i,
  input  logic             mem_resp_error_i
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 40 - ICACHE_OFFSET_W - IDX_W;

  icache_resp_state_t state_q;
  logic [39:2]        vaddr_q;
  logic [31:0]        word_q;
  logic               fault_q;

  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic               rd_valid_s;
  logic [TAG_W-1:0]   rd_tag_s;
  icache_line_t       rd_line_s;
  logic               hit_s;
  logic               ready_s;
  logic               accept_s;
  logic               flush_s;
  logic               fill_s;
  resp_icache_cpu_t   resp_s;
  mem_icache_req_t    mem_req_s;
  mem_icache_resp_t   mem_resp_s;
  logic               unused_s;

  assign unused_s = ^req_cpu_icache_i.vaddr[1:0];

  assign mem_resp_s.valid = mem_resp_valid_i;
  assign mem_resp_s.data  = mem_resp_data_i;
  assign mem_resp_s.error = mem_resp_error_i;

  assign idx_s = vaddr_q[ICACHE_OFFSET_W+IDX_W-1:ICACHE_OFFSET_W];
  assign tag_s = vaddr_q[39:ICACHE_OFFSET_W+IDX_W];

  assign hit_s    = (state_q == ICR_LOOKUP) && rd_valid_s && (rd_tag_s == tag_s);
  assign ready_s  = rstn_i && ((state_q == ICR_IDLE) || hit_s);
  assign accept_s = ready_s && req_cpu_icache_i.valid;
  assign flush_s  = ready_s && req_cpu_icache_i.invalidate_icache;
  assign fill_s   = rstn_i && (state_q == ICR_MISS_WAIT) && mem_resp_s.valid && !mem_resp_s.error;

  icache_resp_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clear_i    (flush_s),
    .rd_idx_i   (idx_s),
    .rd_valid_o (rd_valid_s),
    .rd_tag_o   (rd_tag_s),
    .rd_line_o  (rd_line_s),
    .we_i       (fill_s),
    .wr_idx_i   (idx_s),
    .wr_tag_i   (tag_s),
    .wr_line_i  (mem_resp_s.data)
  );

  // Hits answer in the LOOKUP cycle itself; refills answer from the captured word.
  always_comb begin
    resp_s = '0;
    case (state_q)
      ICR_LOOKUP: begin
        if (hit_s) begin
          resp_s.valid = 1'b1;
          resp_s.data  = icache_word_sel(rd_line_s, vaddr_q[3:2]);
        end else begin
          resp_s.valid = 1'b0;
        end
      end
      ICR_RESPOND: begin
        resp_s.valid              = 1'b1;
        resp_s.data               = word_q;
        resp_s.instr_access_fault = fault_q;
      end
      default: resp_s = '0;
    endcase
  end

  always_comb begin
    mem_req_s.valid = rstn_i && (state_q == ICR_MISS_REQ);
    if (mem_req_s.valid) begin
      mem_req_s.addr = {vaddr_q[39:ICACHE_OFFSET_W], 4'b0000};
    end else begin
      mem_req_s.addr = '0;
    end
  end

  assign ready_o           = ready_s;
  assign resp_icache_cpu_o = rstn_i ? resp_s : '0;
  assign mem_req_valid_o   = mem_req_s.valid;
  assign mem_req_addr_o    = mem_req_s.addr;

  // Fetch FSM with request latch and refill capture.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ICR_IDLE;
      vaddr_q <= '0;
      word_q  <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ICR_IDLE: begin
          if (accept_s) begin
            vaddr_q <= req_cpu_icache_i.vaddr[39:2];
            state_q <= ICR_LOOKUP;
          end
        end
        ICR_LOOKUP: begin
          if (!hit_s) begin
            state_q <= ICR_MISS_REQ;
          end else if (accept_s) begin
            vaddr_q <= req_cpu_icache_i.vaddr[39:2];
            state_q <= ICR_LOOKUP;
          end else begin
            state_q <= ICR_IDLE;
          end
        end
        ICR_MISS_REQ: begin
          if (mem_req_ready_i) begin
            state_q <= ICR_MISS_WAIT;
          end
        end
        ICR_MISS_WAIT: begin
          if (mem_resp_s.valid) begin
            word_q  <= mem_resp_s.error ? 32'h0000_0000
                                        : icache_word_sel(mem_resp_s.data, vaddr_q[3:2]);
            fault_q <= mem_resp_s.error;
            state_q <= ICR_RESPOND;
          end
        end
        ICR_RESPOND: begin
          fault_q <= 1'b0;
          state_q <= ICR_IDLE;
        end
        default: state_q <= ICR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_resp_unit.sv
// Scoreboard bench for icache_resp_unit: directed scenarios then random fetches
// against a line-address cache model and a memory model.
module tb_icache_resp_unit;
  import drac_pkg::*;

  localparam int NL = 8;

  logic             clk = 1'b0;
  logic             rstn;
  req_cpu_icache_t  req;
  logic             ready;
  resp_icache_cpu_t resp;
  logic             mreq_v;
  addr_t            mreq_a;
  logic             mreq_rdy;
  logic             mresp_v;
  icache_line_t     mresp_d;
  logic             mresp_err;

  always #5 clk = ~clk;

  icache_resp_unit #(.NUM_LINES(NL)) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .req_cpu_icache_i  (req),
    .ready_o           (ready),
    .resp_icache_cpu_o (resp),
    .mem_req_valid_o   (mreq_v),
    .mem_req_addr_o    (mreq_a),
    .mem_req_ready_i   (mreq_rdy),
    .mem_resp_valid_i  (mresp_v),
    .mem_resp_data_i   (mresp_d),
    .mem_resp_error_i  (mresp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic        fault;
    bit          hit;
    int          acc;
  } exp_t;

  exp_t         exp_q[$];
  addr_t        refill_q[$];
  bit           mv[NL];
  addr_t        mtag[NL];
  icache_line_t mem_ovr[addr_t];
  bit           mem_err[addr_t];

  function automatic icache_line_t mem_line(input addr_t la);
    icache_line_t l;
    if (mem_ovr.exists(la)) return mem_ovr[la];
    for (int k = 0; k < 4; k++) l[32*k +: 32] = la[31:0] ^ (32'h9E37_79B9 * (k + 1));
    return l;
  endfunction

  task automatic model_clear();
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  task automatic model_accept(input addr_t va, input bit inv);
    addr_t        la;
    int           idx;
    exp_t         e;
    icache_line_t sh;
    la = {va[39:4], 4'h0};
    idx = int'((la >> 4) % NL);
    if (inv) model_clear();
    e.acc = cyc;
    e.hit = mv[idx] && (mtag[idx] == la);
    sh = mem_line(la) >> (32 * int'(va[3:2]));
    e.data  = sh[31:0];
    e.fault = 1'b0;
    if (!e.hit) begin
      refill_q.push_back(la);
      if (mem_err.exists(la)) begin
        e.data  = 32'h0;
        e.fault = 1'b1;
      end else begin
        mv[idx]   = 1'b1;
        mtag[idx] = la;
      end
    end
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (rstn && resp.valid) begin
      check("resp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("resp_data", resp.data, mon_e.data);
        check("resp_access_fault", resp.instr_access_fault, mon_e.fault);
        check("resp_page_fault", resp.instr_page_fault, 0);
        if (mon_e.hit) check("hit_latency", cyc - mon_e.acc, 1);
        else           check("miss_latency_min", (cyc - mon_e.acc) >= 4, 1);
      end
    end
  end

  // ---------------- memory responder ----------------
  int rand_mem   = 0;
  int req_stall  = 0;
  int resp_delay = 0;
  int mreq_cnt   = 0;
  bit resp_busy  = 0;
  bit mreq_acked = 0;

  initial begin
    addr_t ra;
    int    st;
    int    dl;
    mreq_rdy  = 1'b0;
    mresp_v   = 1'b0;
    mresp_err = 1'b0;
    mresp_d   = '0;
    forever begin
      @(negedge clk);
      if (rstn && mreq_v) begin
        resp_busy = 1'b1;
        mreq_cnt++;
        ra = mreq_a;
        check("refill_expected", refill_q.size() != 0, 1);
        if (refill_q.size() != 0) check("refill_addr", ra, refill_q.pop_front());
        st = (rand_mem != 0) ? int'($urandom_range(0, 3)) : req_stall;
        for (int i = 0; i < st; i++) begin
          @(negedge clk);
          check("mreq_valid_held", mreq_v, 1);
          check("mreq_addr_held", mreq_a, ra);
        end
        mreq_rdy = 1'b1;
        @(negedge clk);
        mreq_rdy   = 1'b0;
        mreq_acked = 1'b1;
        dl = (rand_mem != 0) ? int'($urandom_range(0, 3)) : resp_delay;
        repeat (dl) @(negedge clk);
        mresp_v   = 1'b1;
        mresp_d   = mem_line(ra);
        mresp_err = mem_err.exists(ra);
        @(negedge clk);
        mresp_v   = 1'b0;
        mresp_err = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input addr_t va, input bit vld, input bit inv, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    req.valid = vld;
    req.vaddr = va;
    req.invalidate_icache = inv;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (ready) ok = 1'b1;
      else       waited++;
    end
    check("req_accepted", ok, 1);
    if (ok) begin
      if (vld) model_accept(va, inv);
      else     model_clear();
    end
    @(posedge clk);
    #1;
    req = '0;
  endtask

  task automatic fetch(input addr_t va);
    int w;
    drive(va, 1'b1, 1'b0, w);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !resp_busy) done = 1'b1;
    end
    check("drain", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    exp_q.delete();
    refill_q.delete();
    model_clear();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_ready", ready, 0);
      check("rst_resp_valid", resp.valid, 0);
      check("rst_mreq_valid", mreq_v, 0);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    w;
    int    c0;
    addr_t va;
    addr_t bases[4];
    rstn = 1'b0;
    req  = '0;
    mem_ovr[40'h00_0000_1000] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    mem_err[40'h00_0000_2000] = 1'b1;

    do_reset(3);

    // cold miss
    c0 = mreq_cnt;
    fetch(40'h00_0000_1004);
    drain();
    check("cold_miss_mreq", mreq_cnt, c0 + 1);

    // hit stream, back to back
    c0 = mreq_cnt;
    for (int k = 0; k < 4; k++) begin
      va = 40'h00_0000_1000 + 40'(4 * k);
      drive(va, 1'b1, 1'b0, w);
      check("hit_stream_no_wait", w, 0);
    end
    drain();
    check("hit_stream_no_mreq", mreq_cnt, c0);

    // conflict on index 0
    c0 = mreq_cnt;
    fetch(40'h00_0000_1080);
    fetch(40'h00_0000_1000);
    drain();
    check("conflict_refills", mreq_cnt, c0 + 2);

    // refill error, then retry
    c0 = mreq_cnt;
    fetch(40'h00_0000_2000);
    fetch(40'h00_0000_2000);
    drain();
    check("error_retry_refills", mreq_cnt, c0 + 2);

    // invalidate only, then refetch
    fetch(40'h00_0000_1000);
    drain();
    c0 = mreq_cnt;
    drive(40'h0, 1'b0, 1'b1, w);
    fetch(40'h00_0000_1000);
    drain();
    check("invalidate_refill", mreq_cnt, c0 + 1);

    // memory backpressure
    req_stall = 5;
    fetch(40'h00_0000_4008);
    drain();
    req_stall = 0;

    // reset in MISS_WAIT; late memory response must be ignored
    resp_delay = 8;
    mreq_acked = 1'b0;
    fetch(40'h00_0000_3004);
    for (int i = 0; i < 100 && !mreq_acked; i++) @(negedge clk);
    check("mreq_acked", mreq_acked, 1);
    do_reset(2);
    drain();
    resp_delay = 0;
    c0 = mreq_cnt;
    fetch(40'h00_0000_3004);
    drain();
    check("post_reset_refill", mreq_cnt, c0 + 1);

    // random phase
    rand_mem = 1;
    bases[0] = 40'h00_0000_5000;
    bases[1] = 40'h00_0000_5080;
    bases[2] = 40'h00_0000_5100;
    bases[3] = 40'hAB_0000_5000;
    mem_err[40'h00_0000_5010] = 1'b1;
    mem_err[40'h00_0000_5150] = 1'b1;
    for (int n = 0; n < 300; n++) begin
      va = bases[$urandom_range(0, 3)] + 40'(16 * $urandom_range(0, 7))
         + 40'(4 * $urandom_range(0, 3)) + 40'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) begin
        drive(40'h0, 1'b0, 1'b1, w);
      end else begin
        drive(va, 1'b1, ($urandom_range(0, 19) == 0), w);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
